// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_ctrl_pkg: shared constants and types for the register-file write-back controller
// Provides XLEN/REG_AW/NUM_REGS, address and data typedefs, and the x0 address constant.
package regfile_ctrl_pkg;
   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;
   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   xlen_t;
   localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// regfile_wb_ctrl_if: decode, write-back requester and register-file write port bundle
// master: decode/requester side (drives iss_*, rs*_addr, req_valid/addr/data)
// slave : controller side (drives iss_ready, rd_hazard, req_ready, wr_*)
interface regfile_wb_ctrl_if #(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = regfile_ctrl_pkg::XLEN,
   parameter int REG_AW  = regfile_ctrl_pkg::REG_AW
);
   logic                      iss_valid;
   logic [REG_AW-1:0]         iss_rd;
   logic                      iss_ready;
   logic [REG_AW-1:0]         rs1_addr;
   logic [REG_AW-1:0]         rs2_addr;
   logic                      rd_hazard;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*REG_AW-1:0] req_addr;
   logic [NUM_REQ*XLEN-1:0]   req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      wr_en;
   logic [REG_AW-1:0]         wr_addr;
   logic [XLEN-1:0]           wr_data;
   modport master (
      output iss_valid, iss_rd, rs1_addr, rs2_addr, req_valid, req_addr, req_data,
      input  iss_ready, rd_hazard, req_ready, wr_en, wr_addr, wr_data
   );
   modport slave (
      input  iss_valid, iss_rd, rs1_addr, rs2_addr, req_valid, req_addr, req_data,
      output iss_ready, rd_hazard, req_ready, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/regfile_wb_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, first requester at or after ptr wins
// req: request vector; ptr: highest-priority index; grant: one-hot; idx: granted index; any: some grant
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] idx,
   output logic          any
);
   // Scan from the farthest offset down so the nearest requester after ptr is the last one written.
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % N]) begin
            grant = '0;
            grant[(int'(ptr) + k) % N] = 1'b1;
            idx = PW'((int'(ptr) + k) % N);
         end
      end
   end
   assign any = |req;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin write-back arbitration, registered write port and destination scoreboard
// clk/reset: clock and synchronous active-high reset
// bus.iss_*: reserve a destination; bus.rs*_addr/rd_hazard: operand hazard check
// bus.req_*: per-requester write-back handshake; bus.wr_*: register-file write port (1-cycle latency)
module regfile_wb_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int XLEN    = regfile_ctrl_pkg::XLEN,
   parameter int REG_AW  = regfile_ctrl_pkg::REG_AW
) (
   input logic               clk,
   input logic               reset,
   regfile_wb_ctrl_if.slave  bus
);
   localparam int NR = 1 << REG_AW;
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   logic [NR-1:0]      busy, busy_nxt;
   logic [PW-1:0]      rr_ptr, g_idx;
   logic [NUM_REQ-1:0] grant;
   logic               any;
   logic [REG_AW-1:0]  g_addr;
   logic [XLEN-1:0]    g_data;
   logic               iss_take;
   logic               wr_en_q;
   logic [REG_AW-1:0]  wr_addr_q;
   logic [XLEN-1:0]    wr_data_q;
   rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (g_idx),
      .any   (any)
   );
   assign g_addr        = bus.req_addr[g_idx*REG_AW +: REG_AW];
   assign g_data        = bus.req_data[g_idx*XLEN +: XLEN];
   assign bus.req_ready = reset ? '0 : grant;
   assign bus.iss_ready = !reset && !(busy[bus.iss_rd] && bus.iss_rd != REG_AW'(REG_ZERO));
   assign iss_take      = bus.iss_valid && bus.iss_ready && bus.iss_rd != REG_AW'(REG_ZERO);
   assign bus.rd_hazard = busy[bus.rs1_addr] | busy[bus.rs2_addr];
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   // Clear from the write in flight, then set from issue so a same-index collision keeps the reservation.
   always_comb begin
      busy_nxt = busy;
      if (wr_en_q) busy_nxt[wr_addr_q] = 1'b0;
      if (iss_take) busy_nxt[bus.iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end
   // Writes to x0 are consumed but never reach the register file; the write port keeps its last address/data.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy      <= '0;
         rr_ptr    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         busy    <= busy_nxt;
         wr_en_q <= any && g_addr != REG_AW'(REG_ZERO);
         if (any) rr_ptr <= (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
         if (any && g_addr != REG_AW'(REG_ZERO)) begin
            wr_addr_q <= g_addr;
            wr_data_q <= g_data;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed vector table plus randomized run against a behavioural scoreboard model
module tb_regfile_wb_ctrl;
   import regfile_ctrl_pkg::*;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   regfile_wb_ctrl_if #(.NUM_REQ(2)) bus();
   regfile_wb_ctrl #(.NUM_REQ(2)) dut (.clk(clk), .reset(reset), .bus(bus));
   typedef struct {
      logic       rst;
      logic       iv;
      logic [4:0] ird, rs1, rs2;
      logic [1:0] rv;
      logic [4:0] a0, a1;
      logic [31:0] d0, d1;
      logic [1:0] e_rr;
      logic       e_ir, e_hz, e_we;
      logic [4:0] e_wa;
      logic [31:0] e_wd;
   } vec_t;
   vec_t tbl[$];
   int n_cmp = 0;
   int n_bad = 0;
   logic m_busy[32];
   int   m_ptr;
   logic m_wen;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   logic        pend[2];
   logic [4:0]  p_addr[2];
   logic [31:0] p_data[2];
   function automatic vec_t mk(logic rst, logic iv, int ird, int rs1, int rs2, logic [1:0] rv,
                               int a0, int a1, logic [31:0] d0, logic [31:0] d1, logic [1:0] e_rr,
                               logic e_ir, logic e_hz, logic e_we, int e_wa, logic [31:0] e_wd);
      vec_t v;
      v.rst = rst; v.iv = iv; v.ird = 5'(ird); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rv = rv;
      v.a0 = 5'(a0); v.a1 = 5'(a1); v.d0 = d0; v.d1 = d1; v.e_rr = e_rr;
      v.e_ir = e_ir; v.e_hz = e_hz; v.e_we = e_we; v.e_wa = 5'(e_wa); v.e_wd = e_wd;
      return v;
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask
   function automatic logic [1:0] m_grant();
      logic [1:0] g = '0;
      if (reset) return g;
      for (int k = 0; k < 2; k++)
         if (bus.req_valid[(m_ptr + k) % 2]) begin
            g[(m_ptr + k) % 2] = 1'b1;
            return g;
         end
      return g;
   endfunction
   function automatic logic m_iss_ready();
      return !reset && !(m_busy[bus.iss_rd] && bus.iss_rd != 0);
   endfunction
   function automatic logic m_hazard();
      return m_busy[bus.rs1_addr] || m_busy[bus.rs2_addr];
   endfunction
   // Advance the model across one rising edge using the inputs currently driven.
   task automatic m_step();
      logic [1:0] g;
      logic ir;
      logic [4:0] a;
      g  = m_grant();
      ir = m_iss_ready();
      if (reset) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_ptr = 0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
      end else begin
         if (m_wen) m_busy[m_waddr] = 1'b0;
         if (bus.iss_valid && ir && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
         m_wen = 1'b0;
         for (int i = 0; i < 2; i++)
            if (g[i]) begin
               m_ptr = (i + 1) % 2;
               a = bus.req_addr[i*5 +: 5];
               if (a != 0) begin
                  m_wen = 1'b1; m_waddr = a; m_wdata = bus.req_data[i*32 +: 32];
               end
            end
      end
   endtask
   task automatic drive(vec_t v);
      reset         = v.rst;
      bus.iss_valid = v.iv;
      bus.iss_rd    = v.ird;
      bus.rs1_addr  = v.rs1;
      bus.rs2_addr  = v.rs2;
      bus.req_valid = v.rv;
      bus.req_addr  = {v.a1, v.a0};
      bus.req_data  = {v.d1, v.d0};
   endtask
   initial begin
      logic [31:0] mb;
      logic [1:0]  g;
      tbl.push_back(mk(1,0,0,0,0,2'b11,5,6,32'hAAAA0000,32'h0000BBBB,2'b00,0,0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,2'b11,5,6,32'hAAAA0000,32'h0000BBBB,2'b00,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,2'b11,5,6,32'hAAAA0000,32'h0000BBBB,2'b01,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,0,2'b11,5,6,32'hAAAA0000,32'h0000BBBB,2'b10,1,0,1,5,32'hAAAA0000));
      tbl.push_back(mk(0,0,0,0,0,2'b00,5,6,32'hAAAA0000,32'h0000BBBB,2'b00,1,0,1,6,32'h0000BBBB));
      tbl.push_back(mk(0,1,7,7,0,2'b00,0,0,0,0,2'b00,1,0,0,6,32'h0000BBBB));
      tbl.push_back(mk(0,1,7,7,0,2'b10,0,7,0,32'h12345678,2'b10,0,1,0,6,32'h0000BBBB));
      tbl.push_back(mk(0,0,7,7,0,2'b00,0,7,0,32'h12345678,2'b00,0,1,1,7,32'h12345678));
      tbl.push_back(mk(0,0,7,7,7,2'b00,0,0,0,0,2'b00,1,0,0,7,32'h12345678));
      tbl.push_back(mk(0,1,0,0,0,2'b01,0,0,32'hFFFFFFFF,0,2'b01,1,0,0,7,32'h12345678));
      tbl.push_back(mk(0,0,0,0,0,2'b00,0,0,0,0,2'b00,1,0,0,7,32'h12345678));
      tbl.push_back(mk(0,1,3,0,0,2'b00,0,0,0,0,2'b00,1,0,0,7,32'h12345678));
      tbl.push_back(mk(0,0,3,3,0,2'b01,3,0,32'h33333333,0,2'b01,0,1,0,7,32'h12345678));
      tbl.push_back(mk(1,0,3,3,0,2'b00,3,0,32'h33333333,0,2'b00,0,1,1,3,32'h33333333));
      tbl.push_back(mk(0,0,3,3,0,2'b00,0,0,0,0,2'b00,1,0,0,0,0));
      tbl.push_back(mk(0,0,0,9,0,2'b11,9,11,32'h99,32'hBB,2'b01,1,0,0,0,0));
      tbl.push_back(mk(0,1,9,9,0,2'b10,9,11,32'h99,32'hBB,2'b10,1,0,1,9,32'h99));
      tbl.push_back(mk(0,0,9,9,0,2'b00,0,0,0,0,2'b00,0,1,1,11,32'hBB));
      tbl.push_back(mk(0,0,11,11,9,2'b00,0,0,0,0,2'b00,1,1,0,11,32'hBB));
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("v%0d req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rr));
         chk($sformatf("v%0d iss_ready", i), 32'(bus.iss_ready), 32'(tbl[i].e_ir));
         chk($sformatf("v%0d rd_hazard", i), 32'(bus.rd_hazard), 32'(tbl[i].e_hz));
         if (i > 0) begin
            chk($sformatf("v%0d wr_en", i), 32'(bus.wr_en), 32'(tbl[i].e_we));
            chk($sformatf("v%0d wr_addr", i), 32'(bus.wr_addr), 32'(tbl[i].e_wa));
            chk($sformatf("v%0d wr_data", i), bus.wr_data, tbl[i].e_wd);
         end
         if (i == 16 || i == 17) chk($sformatf("v%0d busy9", i), 32'(dut.busy[9]), 32'(i == 17));
         m_step();
      end
      foreach (pend[i]) pend[i] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset = (c < 2) || ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 2; i++)
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               p_addr[i] = 5'($urandom_range(0, 7));
               p_data[i] = $urandom;
            end
         bus.req_valid = {pend[1], pend[0]};
         bus.req_addr  = {p_addr[1], p_addr[0]};
         bus.req_data  = {p_data[1], p_data[0]};
         bus.iss_valid = 1'($urandom_range(0, 1));
         bus.iss_rd    = 5'($urandom_range(0, 7));
         bus.rs1_addr  = 5'($urandom_range(0, 7));
         bus.rs2_addr  = 5'($urandom_range(0, 7));
         #1;
         g = m_grant();
         for (int i = 0; i < 32; i++) mb[i] = m_busy[i];
         chk("rnd req_ready", 32'(bus.req_ready), 32'(g));
         chk("rnd iss_ready", 32'(bus.iss_ready), 32'(m_iss_ready()));
         chk("rnd rd_hazard", 32'(bus.rd_hazard), 32'(m_hazard()));
         if (c > 0) begin
            chk("rnd wr_en", 32'(bus.wr_en), 32'(m_wen));
            chk("rnd wr_addr", 32'(bus.wr_addr), 32'(m_waddr));
            chk("rnd wr_data", bus.wr_data, m_wdata);
            chk("rnd busy", dut.busy, mb);
         end
         for (int i = 0; i < 2; i++) if (g[i]) pend[i] = 1'b0;
         m_step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
